// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and helpers for the iterative RV32M multiply/divide unit
package muldiv_pkg;

  localparam int MULDIV_XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic [MULDIV_XLEN-1:0] negate(input logic [MULDIV_XLEN-1:0] v);
    return ~v + MULDIV_XLEN'(1);
  endfunction

  // Magnitude of v when it is to be read as a negative two's-complement value.
  function automatic logic [MULDIV_XLEN-1:0] abs_val(input logic [MULDIV_XLEN-1:0] v,
                                                      input logic is_neg);
    return is_neg ? negate(v) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - one shift-add multiply or restoring-divide step per enabled cycle
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic            en_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_nxt_o,
  output logic [XLEN-1:0] lo_nxt_o
);

  logic            r_div;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;

  // Multiply: hi accumulates b when the multiplier LSB in lo is set, then {carry,hi,lo} shifts right.
  assign w_sum   = {1'b0, r_hi} + {1'b0, r_b};
  assign w_add   = r_lo[0] ? w_sum : {1'b0, r_hi};

  // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
  // Bit XLEN of the trial difference is set exactly when the subtraction would go negative.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_b};

  always_comb begin
    hi_nxt_o = r_hi;
    lo_nxt_o = r_lo;
    if (r_div) begin
      if (!w_trial[XLEN]) begin
        hi_nxt_o = w_trial[XLEN-1:0];
        lo_nxt_o = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt_o = w_shift[XLEN-1:0];
        lo_nxt_o = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt_o = w_add[XLEN:1];
      lo_nxt_o = {w_add[0], r_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_div <= 1'b0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (load_i) begin
      r_div <= div_i;
      r_b   <= b_i;
      r_hi  <= '0;
      r_lo  <= a_i;
    end else if (en_i) begin
      r_hi  <= hi_nxt_o;
      r_lo  <= lo_nxt_o;
    end
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// rtl/muldiv_seq_unit.sv - sequencing FSM, operand sign handling, result handshake and hazard output
module muldiv_seq_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = MULDIV_XLEN,
  parameter bit FAST_SPEC = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  input  logic [4:0]      src1_dec_i,
  input  logic [4:0]      src2_dec_i,
  input  logic            muldiv_dec_i,
  output logic            busy_o,
  output logic            muldiv_hazard_o,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      result_rd_o
);

  localparam int CW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;

  muldiv_state_e   r_state;
  muldiv_state_e   w_state_nxt;
  muldiv_op_e      r_op;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_spec_result;
  logic            r_special;
  logic            r_neg_q;
  logic            r_neg_r;

  muldiv_op_e      w_op;
  logic            w_accept;
  logic            w_last;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_is_div;
  logic            w_sa;
  logic            w_sb;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN-1:0] w_spec_result;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  logic [PW-1:0]   w_prod_raw;
  logic [PW-1:0]   w_prod;
  logic [XLEN-1:0] w_final;

  assign w_op     = muldiv_op_e'(op_i);
  assign w_accept = (r_state == ST_IDLE) && start_i && !flush_i;
  assign w_last   = (r_state == ST_CALC) && (r_cnt == CW'(XLEN - 1));

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    w_is_div   = 1'b0;
    case (w_op)
      OP_MUL, OP_MULH: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      OP_MULHSU: w_a_signed = 1'b1;
      OP_DIV, OP_REM: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
        w_is_div   = 1'b1;
      end
      OP_DIVU, OP_REMU: w_is_div = 1'b1;
      default: ;
    endcase
  end

  assign w_sa     = w_a_signed && rs1_val_i[XLEN-1];
  assign w_sb     = w_b_signed && rs2_val_i[XLEN-1];
  assign w_a_abs  = abs_val(rs1_val_i, w_sa);
  assign w_b_abs  = abs_val(rs2_val_i, w_sb);

  // Divide corner cases resolve to fixed results; op_i[1] distinguishes REM/REMU from DIV/DIVU.
  assign w_b_zero  = (rs2_val_i == '0);
  assign w_ovf     = w_a_signed && (rs1_val_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val_i == '1);
  assign w_special = w_is_div && (w_b_zero || w_ovf);

  always_comb begin
    w_spec_result = '0;
    if (w_b_zero)
      w_spec_result = op_i[1] ? rs1_val_i : '1;
    else if (w_ovf)
      w_spec_result = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (w_accept),
    .en_i     ((r_state == ST_CALC) && !flush_i),
    .div_i    (w_is_div),
    .a_i      (w_a_abs),
    .b_i      (w_b_abs),
    .hi_nxt_o (w_hi_nxt),
    .lo_nxt_o (w_lo_nxt)
  );

  // Sign fix-up operates on the core's final-step values so the result is registered on the last CALC edge.
  assign w_prod_raw = {w_hi_nxt, w_lo_nxt};
  assign w_prod     = r_neg_q ? (~w_prod_raw + PW'(1)) : w_prod_raw;

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[PW-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = r_neg_q ? negate(w_lo_nxt) : w_lo_nxt;
      default:                      w_final = r_neg_r ? negate(w_hi_nxt) : w_hi_nxt;
    endcase
    if (r_special)
      w_final = r_spec_result;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_state_nxt = (FAST_SPEC && w_special) ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (flush_i)
          w_state_nxt = ST_IDLE;
        else if (w_last)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (flush_i || result_ready_i)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_op          <= OP_MUL;
      r_rd          <= '0;
      r_cnt         <= '0;
      r_result      <= '0;
      r_spec_result <= '0;
      r_special     <= 1'b0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
    end else if (w_accept) begin
      r_op          <= w_op;
      r_rd          <= rd_i;
      r_cnt         <= '0;
      r_neg_q       <= w_sa ^ w_sb;
      r_neg_r       <= w_sa;
      r_special     <= w_special;
      r_spec_result <= w_spec_result;
      if (FAST_SPEC && w_special)
        r_result <= w_spec_result;
    end else if ((r_state == ST_CALC) && !flush_i) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      if (w_last)
        r_result <= w_final;
    end
  end

  assign busy_o          = (r_state != ST_IDLE);
  assign result_valid_o  = (r_state == ST_DONE);
  assign result_o        = r_result;
  assign result_rd_o     = r_rd;
  assign muldiv_hazard_o = busy_o &&
                           (((r_rd != 5'd0) && ((src1_dec_i == r_rd) || (src2_dec_i == r_rd))) ||
                            muldiv_dec_i);

endmodule
